fc_argmax: RTL
==============

# fc_argmax

Classifier stage directly downstream of the final `flatten_fc_layer`/`fc_func` output. It captures the per-tile, per-channel output beats of the last fully-connected layer into a neuron-indexed register buffer. On the layer's start pulse it scans all `OUTPUT_NEURONS` values sequentially and reports the index and value of the largest signed activation.

## Interface
Parameters:
- `DATA_SIZE`, 8, activation width, signed two's complement
- `OUTPUT_NEURONS`, 10, number of valid neurons (N); must be ≥1
- `XBAR_SIZE`, 128, crossbar width
- `OBUF_BUS_WIDTH`, 48, upstream obuf bus width
- `OBUF_DATA_SIZE`, (DATA_SIZE==1) ? $clog2(XBAR_SIZE) : 2*DATA_SIZE+$clog2(XBAR_SIZE)
- `H_CIM_TILES`, ceil(OUTPUT_NEURONS*DATA_SIZE/XBAR_SIZE)
- `NUM_CHANNELS`, floor(OBUF_BUS_WIDTH/OBUF_DATA_SIZE), elements per tile per beat
- `ELEMENTS_PER_TILE`, floor(XBAR_SIZE/DATA_SIZE)
- `NUM_ADDR_OBUF`, ELEMENTS_PER_TILE/NUM_CHANNELS, beats per frame
- `CLASS_WIDTH`, (N≤1) ? 1 : $clog2(N)

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: reset, synchronous, active-high
- `i_we` in 1: one output beat valid
- `i_data` in `[DATA_SIZE-1:0] [H_CIM_TILES-1:0][NUM_CHANNELS-1:0]`: beat payload
- `i_start` in 1: frame complete, begin scan (pulse)
- `o_ready` out 1: high in IDLE only
- `o_class` out CLASS_WIDTH: index of max neuron
- `o_max` out DATA_SIZE: max value
- `o_valid` out 1: one-cycle pulse, result updated

## Operation
- States: IDLE, LOAD, SCAN, DONE.
- Beat counter `k` (width max(1, $clog2(NUM_ADDR_OBUF+1))):
  - Each `i_we` accepted in IDLE writes element (t,c) to neuron n = t*ELEMENTS_PER_TILE + k*NUM_CHANNELS + c.
  - The write is suppressed if n ≥ N or k*NUM_CHANNELS+c ≥ ELEMENTS_PER_TILE.
  - `k` then increments, saturating at NUM_ADDR_OBUF. Further beats are dropped.
- Neuron buffer: N×DATA_SIZE registers, not reset. Unwritten neurons keep their previous frame's value.
- IDLE:
  - `i_start` → LOAD.
  - A same-cycle `i_we` is written and included in the scan.
- LOAD: max ← buf[0], class ← 0, idx ← 1. Then → SCAN, or → DONE if N==1.
- SCAN: if signed buf[idx] > max, then max ← buf[idx] and class ← idx.
  - Strict compare, so ties keep the lowest index.
  - idx==N-1 → DONE; otherwise idx+1.
- DONE: `o_valid`=1, `o_class`/`o_max` hold the final result, `k` ← 0. Then → IDLE.
- Ignored inputs:
  - `i_we` outside IDLE: ignored, `k` unchanged.
  - `i_start` outside IDLE: ignored.
- `o_class`/`o_max` hold their value until the next DONE. They are updated only at DONE, from internal registers, and not during the scan.

## Timing
- Cycle 0 = cycle `i_start` is sampled high in IDLE.
- Cycle 1: LOAD, `o_ready`=0.
- Cycles 2..N: SCAN.
- Cycle N+1: DONE with `o_valid`=1.
- Cycle N+2: IDLE with `o_ready`=1.
- Latency from start to `o_valid` is N+1 cycles for all N ≥ 1, including N=1 (DONE at cycle 2).
- Throughput: one frame per N+2 cycles, excluding beat transfer.
- Reset values: state IDLE, `o_ready`=1, `o_valid`=0, `o_class`=0, `o_max`=0, `k`=0.
- Reset mid-operation: returns to IDLE next cycle. No `o_valid` is produced. Buffer contents are undefined to the user.
- All outputs are registered or decoded from state. There is no combinational path from inputs to outputs.

## Test plan
All scenarios use default parameters (H_CIM_TILES=1, NUM_CHANNELS=2, ELEMENTS_PER_TILE=16, NUM_ADDR_OBUF=8).
- Basic frame with tie:
  - Stimulus: beats (c0,c1) = (3,-1), (7,2), (0,7), (-5,-8), (1,6), then `i_start`.
  - Required: `o_valid` at cycle 11; `o_class`=2, `o_max`=7 (neuron 2 beats the tie with neuron 5).
- Signed compare:
  - Stimulus: all neurons -100 except neuron 9 = -3; also set neuron 0 = -128.
  - Required: `o_class`=9, `o_max`=-3 (0xFD).
- Start on the last beat:
  - Stimulus: `i_start` asserted in the same cycle as the 5th beat, which carries (0,50).
  - Required: `o_class`=9, `o_max`=50, `o_valid` at cycle 11.
- Padding and overflow beats:
  - Stimulus: beats 5..7 carry 127 (neurons 10..15, out of range), plus a 9th beat of (127,127); valid max is 20 at neuron 4.
  - Required: `o_class`=4, `o_max`=20.
- Inputs ignored while busy, and next frame:
  - Stimulus: during SCAN, pulse `i_we` with (100,100) and pulse `i_start`.
  - Required: single `o_valid`, result unaffected. The next frame's first beat lands at neurons 0/1 (`k` restarted at 0).
- Reset mid-scan:
  - Stimulus: `rst` asserted at cycle 5.
  - Required: no `o_valid`. `o_ready`=1, `o_class`=0, `o_max`=0 after reset. A subsequent full frame gives the correct result at N+1.

Source files
------------

// File: rtl/fc_argmax.sv
// fc_argmax: captures the output beats of the last fully-connected layer into a
// neuron-indexed buffer, then scans it on a start pulse. It reports the index
// and value of the largest signed activation. Ties keep the lowest index.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | accepting beats into the buffer, waiting for i_start
// S_LOAD | seed running max/class from neuron 0
// S_SCAN | compare one neuron per cycle against the running max
// S_DONE | result published on o_class/o_max, o_valid high, beat count cleared
module fc_argmax #(
    parameter int DATA_SIZE         = 8,
    parameter int OUTPUT_NEURONS    = 10,
    parameter int XBAR_SIZE         = 128,
    parameter int OBUF_BUS_WIDTH    = 48,
    parameter int OBUF_DATA_SIZE    = (DATA_SIZE == 1) ? $clog2(XBAR_SIZE)
                                                       : 2*DATA_SIZE + $clog2(XBAR_SIZE),
    parameter int H_CIM_TILES       = (OUTPUT_NEURONS*DATA_SIZE + XBAR_SIZE - 1) / XBAR_SIZE,
    parameter int NUM_CHANNELS      = OBUF_BUS_WIDTH / OBUF_DATA_SIZE,
    parameter int ELEMENTS_PER_TILE = XBAR_SIZE / DATA_SIZE,
    parameter int NUM_ADDR_OBUF     = ELEMENTS_PER_TILE / NUM_CHANNELS,
    parameter int CLASS_WIDTH       = (OUTPUT_NEURONS <= 1) ? 1 : $clog2(OUTPUT_NEURONS)
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   i_we,
    input  logic [H_CIM_TILES-1:0][NUM_CHANNELS-1:0][DATA_SIZE-1:0] i_data,
    input  logic                                                   i_start,
    output logic                                                   o_ready,
    output logic [CLASS_WIDTH-1:0]                                 o_class,
    output logic [DATA_SIZE-1:0]                                   o_max,
    output logic                                                   o_valid
);

    localparam int K_W = ($clog2(NUM_ADDR_OBUF + 1) < 1) ? 1 : $clog2(NUM_ADDR_OBUF + 1);
    localparam logic [K_W-1:0]         K_SAT     = K_W'(NUM_ADDR_OBUF);
    localparam logic [CLASS_WIDTH-1:0] IDX_FIRST = CLASS_WIDTH'(1);
    localparam logic [CLASS_WIDTH-1:0] IDX_LAST  = CLASS_WIDTH'(OUTPUT_NEURONS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;

    logic [K_W-1:0]                r_k;
    logic [CLASS_WIDTH-1:0]        r_idx;
    logic [CLASS_WIDTH-1:0]        r_class;
    logic signed [DATA_SIZE-1:0]   r_max;
    logic [CLASS_WIDTH-1:0]        r_o_class;
    logic [DATA_SIZE-1:0]          r_o_max;

    logic signed [DATA_SIZE-1:0]   r_buf [OUTPUT_NEURONS];

    logic                          w_accept;
    logic [OUTPUT_NEURONS-1:0]     w_wr_en;
    logic [DATA_SIZE-1:0]          w_wr_data [OUTPUT_NEURONS];
    logic signed [DATA_SIZE-1:0]   w_cand;
    logic                          w_gt;
    logic [CLASS_WIDTH-1:0]        w_fin_class;
    logic signed [DATA_SIZE-1:0]   w_fin_max;

    assign w_accept = (r_state == S_IDLE) && i_we;

    // Static mapping of each neuron to its (tile, beat, channel) slot. Slots past
    // the last beat never match, so saturated-k beats are dropped.
    for (genvar n = 0; n < OUTPUT_NEURONS; n++) begin : g_wr
        localparam int T  = n / ELEMENTS_PER_TILE;
        localparam int E  = n % ELEMENTS_PER_TILE;
        localparam int KN = E / NUM_CHANNELS;
        localparam int CN = E % NUM_CHANNELS;
        assign w_wr_en[n]   = w_accept && (KN < NUM_ADDR_OBUF) && (r_k == K_W'(KN));
        assign w_wr_data[n] = i_data[T][CN];
    end

    // Neuron buffer is deliberately not reset; unwritten neurons keep the previous frame.
    always_ff @(posedge clk) begin
        for (int n = 0; n < OUTPUT_NEURONS; n++) begin
            if (w_wr_en[n]) begin
                r_buf[n] <= w_wr_data[n];
            end
        end
    end

    // Candidate compare and the running result as it will stand after this cycle.
    always_comb begin
        w_cand      = r_buf[r_idx];
        w_gt        = (w_cand > r_max);
        w_fin_class = r_class;
        w_fin_max   = r_max;
        if (r_state == S_LOAD) begin
            w_fin_class = '0;
            w_fin_max   = r_buf[0];
        end else if (w_gt) begin
            w_fin_class = r_idx;
            w_fin_max   = w_cand;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = (OUTPUT_NEURONS == 1) ? S_DONE : S_SCAN;
            S_SCAN: if (r_idx == IDX_LAST) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        o_ready = (r_state == S_IDLE);
        o_valid = (r_state == S_DONE);
    end

    // Beat counter, scan registers, and the published result captured on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k       <= '0;
            r_idx     <= '0;
            r_class   <= '0;
            r_max     <= '0;
            r_o_class <= '0;
            r_o_max   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_we && (r_k != K_SAT)) begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                S_LOAD: begin
                    r_max   <= r_buf[0];
                    r_class <= '0;
                    r_idx   <= IDX_FIRST;
                end
                S_SCAN: begin
                    r_max   <= w_fin_max;
                    r_class <= w_fin_class;
                    r_idx   <= r_idx + CLASS_WIDTH'(1);
                end
                S_DONE: begin
                    r_k <= '0;
                end
                default: ;
            endcase
            if (w_state_nxt == S_DONE && r_state != S_DONE) begin
                r_o_class <= w_fin_class;
                r_o_max   <= w_fin_max;
            end
        end
    end

    assign o_class = r_o_class;
    assign o_max   = r_o_max;

endmodule
